// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing the read side of an async FIFO among NREQ
// consumers in the read clock domain. One consumer is granted at a time for a
// burst of up to BURST_LEN words; the FIFO head word is broadcast on dout and
// qualified per consumer by vld.
// Optional build macro: FIFO_RD_ARB_TIMEOUT_EN -- releases a grant whose
// consumer keeps requesting but stays not-ready for TIMEOUT cycles.
module fifo_rd_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  rdy,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  vld,
  output logic [DSIZE-1:0] dout,
  output logic             busy
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [LW-1:0]   last_q, last_d;

`ifdef FIFO_RD_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0]   stall_q, stall_d;
`endif

  logic          found;
  logic [LW-1:0] pick;
  logic [LW-1:0] k_idx;
  logic          req_g;
  logic          rdy_g;
  logic          beat;

  // Round-robin search: first requesting index strictly after the last grant
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    k_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      k_idx = LW'((int'(last_q) + i) % NREQ);
      if (!found && req[k_idx]) begin
        found = 1'b1;
        pick  = k_idx;
      end
    end
  end

  // A beat needs the granted consumer requesting and ready, and data present
  always_comb begin
    req_g = |(req & gnt_q);
    rdy_g = |(rdy & gnt_q);
    beat  = (state_q == XFER) & req_g & rdy_g & ~rempty;
  end

  assign rinc = beat;
  assign vld  = gnt_q & {NREQ{beat}};
  assign gnt  = gnt_q;
  assign dout = rdata;
  assign busy = (state_q == XFER);

  // Next-state logic: grant on IDLE, count beats and decide release in XFER
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
`ifdef FIFO_RD_ARB_TIMEOUT_EN
    stall_d = stall_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = XFER;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          last_d      = pick;
          cnt_d       = '0;
`ifdef FIFO_RD_ARB_TIMEOUT_EN
          stall_d     = '0;
`endif
        end
      end
      XFER: begin
        if (beat) begin
`ifdef FIFO_RD_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
          if (cnt_q == 8'(BURST_LEN - 1)) begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (!req_g) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end
`ifdef FIFO_RD_ARB_TIMEOUT_EN
        else if (!rdy_g && !rempty) begin
          // Consumer is hogging the grant without accepting data
          if (stall_q == SW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end else begin
            stall_d = stall_q + SW'(1);
          end
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Control registers with synchronous active-high reset
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      last_q  <= LW'(NREQ - 1);
`ifdef FIFO_RD_ARB_TIMEOUT_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
`ifdef FIFO_RD_ARB_TIMEOUT_EN
      stall_q <= stall_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: directed scenarios plus a randomized run, all
// compared against a behavioural model (FIFO as a queue, grant as an index).
module tb_fifo_rd_arbiter;
  localparam int NREQ = 4;
  localparam int DSIZE = 8;
  localparam int BL = 4;
  localparam int TO = 16;

  logic             rclk = 1'b0;
  logic             rrst;
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  rdy;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  vld;
  logic [DSIZE-1:0] dout;
  logic             busy;

  fifo_rd_arbiter #(
    .NREQ(NREQ), .DSIZE(DSIZE), .BURST_LEN(BL), .TIMEOUT(TO)
  ) dut (
    .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .req(req), .rdy(rdy), .gnt(gnt), .vld(vld), .dout(dout), .busy(busy)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int failures = 0;

  logic [DSIZE-1:0] fq[$];

  // Model state: granted index (-1 when idle), beats, last grant, stall cycles
  int m_g = -1;
  int m_cnt = 0;
  int m_last = NREQ - 1;
  int m_stall = 0;

  logic [NREQ-1:0]  e_gnt;
  logic [NREQ-1:0]  e_vld;
  logic             e_rinc;
  logic             e_busy;
  logic [DSIZE-1:0] e_dout;

  function automatic void model_out();
    logic [1:0] gi;
    gi     = m_g[1:0];
    e_busy = (m_g >= 0);
    e_gnt  = (m_g >= 0) ? NREQ'(1 << m_g) : '0;
    e_rinc = (m_g >= 0) && req[gi] && rdy[gi] && (fq.size() > 0);
    e_vld  = e_rinc ? e_gnt : '0;
    e_dout = (fq.size() > 0) ? fq[0] : '0;
  endfunction

  task automatic drive_fifo();
    rempty = (fq.size() == 0);
    rdata  = (fq.size() > 0) ? fq[0] : '0;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) fq.push_back(DSIZE'($urandom));
  endtask

  // Clock one edge: update the model from current inputs, pop on a beat
  task automatic advance();
    int ng;
    int nc;
    int nl;
    int ns;
    logic [1:0] gi;
    ng = m_g; nc = m_cnt; nl = m_last; ns = m_stall;
    gi = m_g[1:0];
    model_out();
    if (rrst) begin
      ng = -1; nc = 0; nl = NREQ - 1; ns = 0;
    end else if (m_g < 0) begin
      for (int i = 1; i <= NREQ; i++) begin
        int k;
        k = (m_last + i) % NREQ;
        if (ng < 0 && req[k[1:0]]) begin
          ng = k; nl = k; nc = 0; ns = 0;
        end
      end
    end else if (e_rinc) begin
      ns = 0;
      if (m_cnt == BL - 1) begin
        ng = -1; nc = 0;
      end else begin
        nc = m_cnt + 1;
      end
    end else if (!req[gi]) begin
      ng = -1; nc = 0;
    end
`ifdef FIFO_RD_ARB_TIMEOUT_EN
    else if (!rdy[gi] && fq.size() > 0) begin
      if (m_stall == TO - 1) begin
        ng = -1; nc = 0;
      end else begin
        ns = m_stall + 1;
      end
    end
`endif
    @(posedge rclk);
    if (e_rinc) void'(fq.pop_front());
    m_g = ng; m_cnt = nc; m_last = nl; m_stall = ns;
    @(negedge rclk);
    drive_fifo();
  endtask

  task automatic do_reset();
    rrst = 1'b1; req = '0; rdy = '0;
    drive_fifo();
    advance();
    rrst = 1'b0;
  endtask

  task automatic test_reset();
    rrst = 1'b1; req = '0; rdy = '1;
    push_words(3);
    drive_fifo();
    advance();
    model_out(); #1;
    checks++;
    if ({gnt, vld, rinc, busy, dout} !== {e_gnt, e_vld, e_rinc, e_busy, e_dout}) begin
      failures++;
      $display("FAIL reset_model got gnt=%b vld=%b rinc=%b busy=%b dout=%h exp gnt=%b vld=%b rinc=%b busy=%b dout=%h",
               gnt, vld, rinc, busy, dout, e_gnt, e_vld, e_rinc, e_busy, e_dout);
    end
    checks++;
    if ({gnt, vld, rinc, busy} !== 10'b0) begin
      failures++;
      $display("FAIL reset_state got gnt=%b vld=%b rinc=%b busy=%b exp all zero", gnt, vld, rinc, busy);
    end
    rrst = 1'b0;
    fq.delete();
    drive_fifo();
  endtask

  task automatic test_single();
    logic [13:0] vmask;
    logic [13:0] gmask;
    int pulses;
    vmask = '0; gmask = '0; pulses = 0;
    push_words(6);
    rdy = '1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      req = (pulses < 6) ? 4'b0001 : 4'b0000;
      drive_fifo(); model_out(); #1;
      checks++;
      if ({gnt, vld, rinc, busy, dout} !== {e_gnt, e_vld, e_rinc, e_busy, e_dout}) begin
        failures++;
        $display("FAIL single cyc=%0d got gnt=%b vld=%b rinc=%b busy=%b dout=%h exp gnt=%b vld=%b rinc=%b busy=%b dout=%h",
                 cyc, gnt, vld, rinc, busy, dout, e_gnt, e_vld, e_rinc, e_busy, e_dout);
      end
      vmask[cyc] = (vld[0] === 1'b1);
      gmask[cyc] = (gnt === 4'b0001);
      if (vld[0] === 1'b1) pulses++;
      advance();
    end
    checks++;
    if (vmask !== 14'h00DE) begin
      failures++;
      $display("FAIL single_vld_pattern got=%b exp=%b", vmask, 14'h00DE);
    end
    checks++;
    if (gmask !== 14'h01DE) begin
      failures++;
      $display("FAIL single_gnt_pattern got=%b exp=%b", gmask, 14'h01DE);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int beats;
    int idx;
    logic [NREQ-1:0] prev;
    do_reset();
    req = 4'b1111; rdy = 4'b1111; beats = 0; prev = '0;
    for (int cyc = 0; cyc < 26; cyc++) begin
      while (fq.size() < 8) push_words(1);
      drive_fifo(); model_out(); #1;
      checks++;
      if ({gnt, vld, rinc, busy, dout} !== {e_gnt, e_vld, e_rinc, e_busy, e_dout}) begin
        failures++;
        $display("FAIL round_robin cyc=%0d got gnt=%b vld=%b rinc=%b busy=%b exp gnt=%b vld=%b rinc=%b busy=%b",
                 cyc, gnt, vld, rinc, busy, e_gnt, e_vld, e_rinc, e_busy);
      end
      if (gnt !== 4'b0000 && prev === 4'b0000) begin
        idx = -1;
        for (int i = 0; i < NREQ; i++) if (gnt[i] === 1'b1) idx = i;
        order.push_back(idx);
      end
      if (vld !== 4'b0000) beats++;
      prev = gnt;
      advance();
    end
    checks++;
    if (order.size() < 5 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3 || order[4] != 0) begin
      failures++;
      $display("FAIL rr_order got n=%0d first=%p exp 0,1,2,3,0", order.size(), order);
    end
    checks++;
    if (beats != 20) begin
      failures++;
      $display("FAIL rr_beats got=%0d exp=20", beats);
    end
  endtask

  task automatic test_empty_stall();
    int beats;
    logic [12:0] gmask;
    do_reset();
    fq.delete();
    rdy = 4'b1111; beats = 0; gmask = '0;
    for (int cyc = 0; cyc < 13; cyc++) begin
      req = (cyc < 12) ? 4'b0100 : 4'b0000;
      if (cyc == 6) push_words(2);
      if (cyc == 10) push_words(5);
      drive_fifo(); model_out(); #1;
      checks++;
      if ({gnt, vld, rinc, busy, dout} !== {e_gnt, e_vld, e_rinc, e_busy, e_dout}) begin
        failures++;
        $display("FAIL empty_stall cyc=%0d got gnt=%b vld=%b rinc=%b busy=%b exp gnt=%b vld=%b rinc=%b busy=%b",
                 cyc, gnt, vld, rinc, busy, e_gnt, e_vld, e_rinc, e_busy);
      end
      checks++;
      if (rinc === 1'b1 && rempty === 1'b1) begin
        failures++;
        $display("FAIL pop_while_empty cyc=%0d got rinc=1 exp rinc=0", cyc);
      end
      gmask[cyc] = (gnt === 4'b0100);
      if (vld[2] === 1'b1) beats++;
      advance();
    end
    checks++;
    if (beats != 4 || gmask !== 13'h0FFE) begin
      failures++;
      $display("FAIL empty_stall_burst got beats=%0d gmask=%b exp beats=4 gmask=%b", beats, gmask, 13'h0FFE);
    end
    fq.delete();
    drive_fifo();
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_words(8);
    req = 4'b1111; rdy = 4'b1111;
    for (int cyc = 0; cyc < 7; cyc++) begin
      rrst = (cyc == 3);
      drive_fifo(); model_out(); #1;
      checks++;
      if ({gnt, vld, rinc, busy, dout} !== {e_gnt, e_vld, e_rinc, e_busy, e_dout}) begin
        failures++;
        $display("FAIL reset_mid cyc=%0d got gnt=%b vld=%b rinc=%b busy=%b exp gnt=%b vld=%b rinc=%b busy=%b",
                 cyc, gnt, vld, rinc, busy, e_gnt, e_vld, e_rinc, e_busy);
      end
      if (cyc == 4) begin
        checks++;
        if (gnt !== 4'b0000 || rinc !== 1'b0) begin
          failures++;
          $display("FAIL reset_mid_abort got gnt=%b rinc=%b exp gnt=0000 rinc=0", gnt, rinc);
        end
      end
      if (cyc == 5) begin
        checks++;
        if (gnt !== 4'b0001) begin
          failures++;
          $display("FAIL reset_mid_first got gnt=%b exp gnt=0001", gnt);
        end
      end
      advance();
    end
    rrst = 1'b0;
  endtask

  task automatic test_drop();
    do_reset();
    fq.delete();
    push_words(8);
    rdy = 4'b1111;
    for (int cyc = 0; cyc < 6; cyc++) begin
      req = (cyc < 2) ? 4'b1000 : (cyc == 2) ? 4'b0000 : 4'b1111;
      drive_fifo(); model_out(); #1;
      checks++;
      if ({gnt, vld, rinc, busy, dout} !== {e_gnt, e_vld, e_rinc, e_busy, e_dout}) begin
        failures++;
        $display("FAIL drop cyc=%0d got gnt=%b vld=%b rinc=%b busy=%b exp gnt=%b vld=%b rinc=%b busy=%b",
                 cyc, gnt, vld, rinc, busy, e_gnt, e_vld, e_rinc, e_busy);
      end
      if (cyc == 2) begin
        checks++;
        if (gnt !== 4'b1000 || rinc !== 1'b0) begin
          failures++;
          $display("FAIL drop_cycle got gnt=%b rinc=%b exp gnt=1000 rinc=0", gnt, rinc);
        end
      end
      if (cyc == 4) begin
        checks++;
        if (gnt !== 4'b0001) begin
          failures++;
          $display("FAIL drop_next_grant got gnt=%b exp gnt=0001", gnt);
        end
      end
      advance();
    end
  endtask

  task automatic test_timeout();
    int held;
    do_reset();
    fq.delete();
    push_words(8);
    rdy = 4'b1101; held = 0;
`ifdef FIFO_RD_ARB_TIMEOUT_EN
    for (int cyc = 0; cyc < 20; cyc++) begin
      req = (cyc >= 17) ? 4'b0110 : 4'b0010;
      drive_fifo(); model_out(); #1;
      checks++;
      if ({gnt, vld, rinc, busy, dout} !== {e_gnt, e_vld, e_rinc, e_busy, e_dout}) begin
        failures++;
        $display("FAIL timeout cyc=%0d got gnt=%b vld=%b rinc=%b busy=%b exp gnt=%b vld=%b rinc=%b busy=%b",
                 cyc, gnt, vld, rinc, busy, e_gnt, e_vld, e_rinc, e_busy);
      end
      if (gnt === 4'b0010) held++;
      if (cyc == 18) begin
        checks++;
        if (gnt !== 4'b0100) begin
          failures++;
          $display("FAIL timeout_next_grant got gnt=%b exp gnt=0100", gnt);
        end
      end
      advance();
    end
    checks++;
    if (held != TO) begin
      failures++;
      $display("FAIL timeout_hold got=%0d exp=%0d", held, TO);
    end
`else
    req = 4'b0010;
    for (int cyc = 0; cyc <= 100; cyc++) begin
      drive_fifo(); model_out(); #1;
      checks++;
      if ({gnt, vld, rinc, busy, dout} !== {e_gnt, e_vld, e_rinc, e_busy, e_dout}) begin
        failures++;
        $display("FAIL no_timeout cyc=%0d got gnt=%b vld=%b rinc=%b busy=%b exp gnt=%b vld=%b rinc=%b busy=%b",
                 cyc, gnt, vld, rinc, busy, e_gnt, e_vld, e_rinc, e_busy);
      end
      if (gnt === 4'b0010) held++;
      if (cyc < 100) advance();
    end
    checks++;
    if (gnt !== 4'b0010 || held != 100) begin
      failures++;
      $display("FAIL no_timeout_hold got gnt=%b held=%0d exp gnt=0010 held=100", gnt, held);
    end
    advance();
`endif
    req = '0;
  endtask

  task automatic test_random();
    do_reset();
    fq.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rrst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
      rdy = NREQ'($urandom) | NREQ'($urandom);
      if (fq.size() < 16 && $urandom_range(0, 2) != 0) push_words($urandom_range(1, 2));
      drive_fifo(); model_out(); #1;
      checks++;
      if ({gnt, vld, rinc, busy, dout} !== {e_gnt, e_vld, e_rinc, e_busy, e_dout}) begin
        failures++;
        $display("FAIL random cyc=%0d got gnt=%b vld=%b rinc=%b busy=%b dout=%h exp gnt=%b vld=%b rinc=%b busy=%b dout=%h",
                 cyc, gnt, vld, rinc, busy, dout, e_gnt, e_vld, e_rinc, e_busy, e_dout);
      end
      if (rinc === 1'b1 && rempty === 1'b1) begin
        checks++;
        failures++;
        $display("FAIL random_pop_empty cyc=%0d got rinc=1 exp rinc=0", cyc);
      end
      advance();
    end
    rrst = 1'b0;
  endtask

  initial begin
    rrst = 1'b1; req = '0; rdy = '0; rempty = 1'b1; rdata = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_empty_stall();
    test_reset_mid();
    test_drop();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
- Round-robin read-port arbiter. It shares the read side of the async FIFO (rempty / rinc / rdata) among NREQ consumers in the read clock domain.
- Grants one requester at a time for a burst of up to BURST_LEN words.
- Pops the FIFO only when the FIFO is non-empty and the granted consumer is ready.
- Broadcasts the FIFO head word to all consumers and qualifies it with a per-consumer valid strobe.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DSIZE, 8, FIFO data width.
- BURST_LEN, 4, maximum words popped per grant (1..255).
- TIMEOUT, 16, stall cycles before a forced release (used only with the optional feature).

Ports:
- rclk  input  1  read-domain clock; all logic is on its rising edge.
- rrst  input  1  synchronous, active-high reset.
- rempty  input  1  FIFO empty flag, registered in rclk.
- rdata  input  DSIZE  FIFO head word; valid whenever rempty=0.
- rinc  output  1  FIFO pop request.
- req  input  NREQ  per-consumer request, level.
- rdy  input  NREQ  per-consumer accept-ready.
- gnt  output  NREQ  one-hot grant, registered.
- vld  output  NREQ  one-hot word strobe; vld[i] = gnt[i] & rinc.
- dout  output  DSIZE  equals rdata (broadcast).
- busy  output  1  high while in XFER.

Interface decision: one clock (rclk); reset rrst is synchronous and active-high.

Behaviour:
- Reset (rrst=1 at a clock edge):
  - state=IDLE, gnt=0, beat count=0, last pointer=NREQ-1, busy=0, stall count=0.
  - Combinational outputs rinc=0 and vld=0 while gnt=0.
  - Reset asserted mid-burst aborts the burst the same edge; no pop occurs in a cycle where gnt=0.
- States:
  - IDLE: if any req bit is set, select the first set bit searching upward from last+1 (modulo NREQ). Register gnt to that one-hot, set last to that index, clear the beat count, go to XFER. Arbitration latency is exactly 1 cycle from req to gnt.
  - XFER: rinc = req[g] & rdy[g] & ~rempty (combinational); each cycle with rinc=1 is a beat and increments the count. Go to IDLE (gnt cleared on that edge) when either condition holds:
    - a beat occurs with count==BURST_LEN-1;
    - req[g]=0 (no beat that cycle).
  - There is always one IDLE cycle between grants (gnt=0, rinc=0).
- rempty=1 in XFER:
  - grant is held, no pop, count frozen;
  - the burst resumes when data arrives;
  - rinc must never be 1 while rempty=1.
- Round robin:
  - the pointer advances on every grant, even for 0-beat grants;
  - a requester re-requesting immediately is served only after all other pending requesters.
- Requests from non-granted consumers are ignored until the next IDLE.
- dout = rdata at all times; consumers capture only on vld.
- The count is 8 bits wide; BURST_LEN=1 yields single-word grants.

Optional Feature:
- Macro: FIFO_RD_ARB_TIMEOUT_EN.
- When defined:
  - a stall counter increments each XFER cycle with req[g]=1 & rdy[g]=0 & rempty=0;
  - it clears on any beat and on entry to XFER;
  - when it reaches TIMEOUT-1, the arbiter goes to IDLE on that edge (gnt cleared, no pop), and the pointer moves past g.
- When not defined: no stall counter; a granted consumer holding req with rdy=0 keeps the grant indefinitely.

Test Plan:
- Reset, then req=4'b0001, rdy=all 1, FIFO holds 6 words -> gnt=0001 one cycle after req; 4 consecutive vld[0] pulses; 1 IDLE cycle; regrant; 2 more beats; then req low -> IDLE.
- req=4'b1111 held, FIFO always non-empty -> grant order 0,1,2,3,0; each grant 4 beats separated by one IDLE cycle.
- Grant to 2 with FIFO empty for 5 cycles, then 2 words written -> rinc=0 while rempty=1; gnt held; 2 beats; count=2, burst continues.
- Mid-burst (after 2 beats) assert rrst for 1 cycle -> gnt=0, rinc=0 next cycle; after release, req=1111 grants requester 0 first.
- With FIFO_RD_ARB_TIMEOUT_EN, TIMEOUT=16: gnt[1] with rdy[1]=0 and data present -> release after 16 stall cycles; next grant goes to requester 2 if requesting. Without the macro -> grant still held at cycle 100.
- req[3] drops after 1 beat -> IDLE next edge; no beat in the drop cycle; last=3, so next search starts at 0.
